// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch front end: default widths,
// reset PC, nop encoding and the fetch-queue entry layout.
package fetch_stage_pkg;

  localparam int PC_WIDTH   = 12;
  localparam int INSN_WIDTH = 32;

  localparam logic [PC_WIDTH-1:0]   RESET_PC = '0;
  localparam logic [INSN_WIDTH-1:0] NOP_INSN = '0;

  typedef struct packed {
    logic [PC_WIDTH-1:0]   pc;
    logic [INSN_WIDTH-1:0] insn;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO with flush; head data is read combinationally.
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 44,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [CNT_W-1:0] count,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage is not reset; validity is tracked entirely by count.
  always_ff @(posedge clock) begin
    if (push && !reset && !flush) mem[wr_ptr] <= push_data;
  end

  assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_stage.sv
// Fetch front end: owns the PC, issues imem reads against a queue credit,
// and hands buffered instructions to decode over valid/ready.
module fetch_stage #(
  parameter int PC_WIDTH   = fetch_stage_pkg::PC_WIDTH,
  parameter int INSN_WIDTH = fetch_stage_pkg::INSN_WIDTH,
  parameter int FQ_DEPTH   = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC = fetch_stage_pkg::RESET_PC
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [PC_WIDTH-1:0]   address_imem,
  input  logic [INSN_WIDTH-1:0] q_imem,
  output logic                  fd_valid,
  input  logic                  fd_ready,
  output logic [INSN_WIDTH-1:0] fd_insn,
  output logic [PC_WIDTH-1:0]   fd_pc,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic [PC_WIDTH-1:0]   pc
);

  import fetch_stage_pkg::*;

  localparam int CNT_W   = $clog2(FQ_DEPTH + 1);
  localparam int ENTRY_W = PC_WIDTH + INSN_WIDTH;

  logic [PC_WIDTH-1:0] pc_reg;
  logic [PC_WIDTH-1:0] inflight_pc;
  logic                inflight_valid;
  logic [CNT_W-1:0]    count;
  logic [ENTRY_W-1:0]  head;
  logic                push;
  logic                pop;
  logic                issue;
  logic [CNT_W:0]      credit;
  logic                queue_empty;

  // Credit counts queued entries plus the read still returning, minus the
  // entry leaving this cycle, so an issued read always has a slot to land in.
  always_comb begin
    queue_empty  = (count == '0);
    address_imem = reset ? RESET_PC : (redirect_valid ? redirect_pc : pc_reg);
    fd_valid     = !reset && !redirect_valid && !queue_empty;
    pop          = fd_valid && fd_ready;
    push         = !reset && inflight_valid && !redirect_valid;
    credit       = (CNT_W+1)'(count) + (CNT_W+1)'(inflight_valid) - (CNT_W+1)'(pop);
    issue        = !reset && (redirect_valid || (credit < (CNT_W+1)'(FQ_DEPTH)));
    fd_insn      = NOP_INSN;
    fd_pc        = '0;
    if (!reset && !queue_empty) begin
      fd_pc   = head[ENTRY_W-1 -: PC_WIDTH];
      fd_insn = head[INSN_WIDTH-1:0];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_reg         <= RESET_PC;
      inflight_valid <= 1'b0;
      inflight_pc    <= RESET_PC;
    end else begin
      inflight_valid <= issue;
      if (issue) begin
        pc_reg      <= address_imem + 1'b1;
        inflight_pc <= address_imem;
      end
    end
  end

  fetch_queue #(
    .DEPTH (FQ_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (push),
    .push_data ({inflight_pc, q_imem}),
    .pop       (pop),
    .count     (count),
    .head_data (head)
  );

  assign pc = pc_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: cycle-exact vector table plus scoreboarded
// sequences for redirects, PC wrap and mid-stream reset.
module tb_fetch_stage;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] address_imem;
  logic [31:0] q_imem;
  logic        fd_valid;
  logic        fd_ready;
  logic [31:0] fd_insn;
  logic [11:0] fd_pc;
  logic        redirect_valid;
  logic [11:0] redirect_pc;
  logic [11:0] pc;

  int total = 0;
  int bad   = 0;
  logic [11:0] sb[$];

  typedef struct {
    logic        rst;
    logic        rdy;
    logic        rv;
    logic [11:0] rpc;
    logic [11:0] e_addr;
    logic        e_valid;
    logic [11:0] e_pc;
    logic [31:0] e_insn;
    logic [11:0] e_pcreg;
  } vec_t;

  vec_t vecs[$];

  fetch_stage dut (
    .clock          (clock),
    .reset          (reset),
    .address_imem   (address_imem),
    .q_imem         (q_imem),
    .fd_valid       (fd_valid),
    .fd_ready       (fd_ready),
    .fd_insn        (fd_insn),
    .fd_pc          (fd_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .pc             (pc)
  );

  always #5 clock = ~clock;

  // Synchronous ROM: word k holds 0x1000 + k, returned one cycle later.
  always @(posedge clock) q_imem <= 32'h1000 + 32'(address_imem);

  function automatic vec_t mk(input logic rst, rdy, rv, input logic [11:0] rpc,
                              input logic [11:0] addr, input logic valid, head,
                              input logic [11:0] hpc, input logic [11:0] pcreg);
    vec_t v;
    v.rst = rst; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.e_addr  = addr;
    v.e_valid = valid;
    v.e_pc    = head ? hpc : 12'h000;
    v.e_insn  = head ? (32'h1000 + 32'(hpc)) : 32'h0;
    v.e_pcreg = pcreg;
    return v;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive inputs just after the edge, then move to mid-cycle for sampling.
  task automatic applyStimulus(input logic r, rdy, rv, input logic [11:0] rpc);
    reset          = r;
    fd_ready       = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    #3;
    if (!reset && fd_valid && fd_ready && sb.size() > 0) begin
      logic [11:0] exp_pc;
      exp_pc = sb.pop_front();
      cmp("sb fd_pc", 32'(fd_pc), 32'(exp_pc));
      cmp("sb fd_insn", fd_insn, 32'h1000 + 32'(exp_pc));
    end
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input int i, input vec_t v);
    cmp($sformatf("row%0d addr", i), 32'(address_imem), 32'(v.e_addr));
    cmp($sformatf("row%0d valid", i), 32'(fd_valid), 32'(v.e_valid));
    cmp($sformatf("row%0d fd_pc", i), 32'(fd_pc), 32'(v.e_pc));
    cmp($sformatf("row%0d fd_insn", i), fd_insn, v.e_insn);
    cmp($sformatf("row%0d pc", i), 32'(pc), 32'(v.e_pcreg));
  endtask

  task automatic run(input int n, input logic rdy);
    for (int k = 0; k < n; k++) begin
      applyStimulus(1'b0, rdy, 1'b0, 12'h000);
      nextCycle();
    end
  endtask

  initial begin
    //                rst rdy rv rpc      addr    v  h  hpc     pcreg
    vecs.push_back(mk(1, 1, 0, 12'h000, 12'h000, 0, 0, 12'h000, 12'h000));
    vecs.push_back(mk(0, 1, 0, 12'h000, 12'h000, 0, 0, 12'h000, 12'h000));
    vecs.push_back(mk(0, 1, 0, 12'h000, 12'h001, 0, 0, 12'h000, 12'h001));
    vecs.push_back(mk(0, 1, 0, 12'h000, 12'h002, 1, 1, 12'h000, 12'h002));
    vecs.push_back(mk(0, 1, 0, 12'h000, 12'h003, 1, 1, 12'h001, 12'h003));
    vecs.push_back(mk(0, 1, 0, 12'h000, 12'h004, 1, 1, 12'h002, 12'h004));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0, 0, 0, 12'h000, 12'h005, 1, 1, 12'h003, 12'h005));
    vecs.push_back(mk(0, 1, 0, 12'h000, 12'h005, 1, 1, 12'h003, 12'h005));
    vecs.push_back(mk(0, 1, 0, 12'h000, 12'h006, 1, 1, 12'h004, 12'h006));
    vecs.push_back(mk(0, 1, 0, 12'h000, 12'h007, 1, 1, 12'h005, 12'h007));
    vecs.push_back(mk(0, 1, 0, 12'h000, 12'h008, 1, 1, 12'h006, 12'h008));
    vecs.push_back(mk(0, 0, 0, 12'h000, 12'h009, 1, 1, 12'h007, 12'h009));
    vecs.push_back(mk(0, 0, 0, 12'h000, 12'h009, 1, 1, 12'h007, 12'h009));
    vecs.push_back(mk(0, 1, 1, 12'h200, 12'h200, 0, 1, 12'h007, 12'h009));
    vecs.push_back(mk(0, 1, 0, 12'h000, 12'h201, 0, 0, 12'h000, 12'h201));
    vecs.push_back(mk(0, 1, 0, 12'h000, 12'h202, 1, 1, 12'h200, 12'h202));
    vecs.push_back(mk(0, 1, 0, 12'h000, 12'h203, 1, 1, 12'h201, 12'h203));

    applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b0, 12'h000);
    nextCycle();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      checkOutput(i, vecs[i]);
      nextCycle();
    end

    // PC wrap after a redirect near the top of the address space.
    sb.delete();
    applyStimulus(1'b0, 1'b1, 1'b1, 12'hFFE);
    cmp("wrap addr", 32'(address_imem), 32'h0FFE);
    sb.push_back(12'hFFE); sb.push_back(12'hFFF); sb.push_back(12'h000);
    sb.push_back(12'h001); sb.push_back(12'h002);
    nextCycle();
    run(6, 1'b1);
    cmp("wrap drained", 32'(sb.size()), 32'd0);

    // Back-to-back redirects: only the second target is delivered.
    sb.delete();
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h010);
    sb.push_back(12'h020); sb.push_back(12'h021); sb.push_back(12'h022);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 12'h020);
    cmp("b2b addr", 32'(address_imem), 32'h0020);
    cmp("b2b valid", 32'(fd_valid), 32'd0);
    nextCycle();
    run(4, 1'b1);
    cmp("b2b drained", 32'(sb.size()), 32'd0);

    // Fill the queue, then reset mid-stream with a redirect competing.
    sb.delete();
    run(3, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 12'h000);
    cmp("full head valid", 32'(fd_valid), 32'd1);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 1'b0, 12'h000);
    cmp("rst valid", 32'(fd_valid), 32'd0);
    cmp("rst addr", 32'(address_imem), 32'h0000);
    cmp("rst fd_pc", 32'(fd_pc), 32'h0000);
    cmp("rst fd_insn", fd_insn, 32'h0);
    nextCycle();
    applyStimulus(1'b1, 1'b1, 1'b1, 12'h300);
    cmp("rst pc", 32'(pc), 32'h0000);
    cmp("rst beats redirect", 32'(address_imem), 32'h0000);
    cmp("rst valid2", 32'(fd_valid), 32'd0);
    nextCycle();
    sb.push_back(12'h000); sb.push_back(12'h001);
    sb.push_back(12'h002); sb.push_back(12'h003);
    run(6, 1'b1);
    cmp("post-reset drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
